ssd_readback: RTL and testbench

SSD_READBACK -- requirements
Module: ssd_readback

---
 rtl/ssd_glyph_pkg.sv | 46 ++++
 rtl/ssd_readback_if.sv | 27 ++
 rtl/ssd_glyph_decode.sv | 23 ++
 rtl/ssd_readback.sv | 192 +++++++++++++++++++
 tb/tb_ssd_readback.sv | 374 +++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ssd_glyph_pkg.sv
// Shared glyph definitions for the seven-segment digit encoder and readback checker.
// Glyphs are 4 columns x 9 rows, stored column-major: bits [c*9 +: 9] hold column c,
// and bit 0 of each column word is the top row. Also holds the readback FSM state type.
package ssd_glyph_pkg;

    localparam int GLYPH_COLS  = 4;
    localparam int GLYPH_ROWS  = 9;
    localparam int GLYPH_BITS  = GLYPH_COLS * GLYPH_ROWS;
    localparam int GLYPH_COUNT = 11;

    localparam logic [3:0] VALUE_BLANK = 4'hE;
    localparam logic [3:0] VALUE_NONE  = 4'hF;

    // Each constant is written {col3, col2, col1, col0}.
    localparam logic [GLYPH_BITS-1:0] GLYPH_0     = {9'h1FF, 9'h101, 9'h101, 9'h1FF};
    localparam logic [GLYPH_BITS-1:0] GLYPH_1     = {9'h1FF, 9'h000, 9'h000, 9'h000};
    localparam logic [GLYPH_BITS-1:0] GLYPH_2     = {9'h11F, 9'h111, 9'h111, 9'h1F1};
    localparam logic [GLYPH_BITS-1:0] GLYPH_3     = {9'h1FF, 9'h111, 9'h111, 9'h111};
    localparam logic [GLYPH_BITS-1:0] GLYPH_4     = {9'h1FF, 9'h010, 9'h010, 9'h01F};
    localparam logic [GLYPH_BITS-1:0] GLYPH_5     = {9'h1F1, 9'h111, 9'h111, 9'h11F};
    localparam logic [GLYPH_BITS-1:0] GLYPH_6     = {9'h1F1, 9'h111, 9'h111, 9'h1FF};
    localparam logic [GLYPH_BITS-1:0] GLYPH_7     = {9'h1FF, 9'h001, 9'h001, 9'h001};
    localparam logic [GLYPH_BITS-1:0] GLYPH_8     = {9'h1FF, 9'h111, 9'h111, 9'h1FF};
    localparam logic [GLYPH_BITS-1:0] GLYPH_9     = {9'h1FF, 9'h111, 9'h111, 9'h11F};
    localparam logic [GLYPH_BITS-1:0] GLYPH_BLANK = '0;

    // Entry i is digit i; the last entry is the blank glyph.
    localparam logic [GLYPH_COUNT-1:0][GLYPH_BITS-1:0] GLYPH_TABLE = {
        GLYPH_BLANK, GLYPH_9, GLYPH_8, GLYPH_7, GLYPH_6, GLYPH_5,
        GLYPH_4, GLYPH_3, GLYPH_2, GLYPH_1, GLYPH_0
    };

    typedef enum logic [2:0] {
        StIdle,
        StDrive,
        StWait,
        StDecode,
        StDone
    } rb_state_e;

    // Flat bit position of (column, row) inside a glyph pattern.
    function automatic logic [5:0] glyph_bit_idx(input logic [1:0] col, input logic [3:0] row);
        return 6'(col) * 6'd9 + 6'(row);
    endfunction

endpackage

// File: rtl/ssd_readback_if.sv
// Host / display-matrix signal bundle for ssd_readback.
// master: the side issuing requests and answering polls; slave: the readback engine.
interface ssd_readback_if;

    logic        start;
    logic [10:0] ObjectX;
    logic [9:0]  ObjectY;
    logic [3:0]  ObjectScale;
    logic [9:0]  PollX;
    logic [8:0]  PollY;
    logic        Hit;
    logic [3:0]  Value;
    logic        Busy;
    logic        Done;
    logic        Error;

    modport master (
        output start, ObjectX, ObjectY, ObjectScale, Hit,
        input  PollX, PollY, Value, Busy, Done, Error
    );

    modport slave (
        input  start, ObjectX, ObjectY, ObjectScale, Hit,
        output PollX, PollY, Value, Busy, Done, Error
    );

endinterface

// File: rtl/ssd_glyph_decode.sv
// Combinational glyph matcher: maps a captured 36-bit pattern to a digit code.
// Exact match only; the blank glyph yields VALUE_BLANK, no match yields VALUE_NONE.
module ssd_glyph_decode
    import ssd_glyph_pkg::*;
(
    input  logic [GLYPH_BITS-1:0] pattern_i,
    output logic [3:0]            value_o,
    output logic                  match_o
);

    // Compare against every glyph; constants are distinct so at most one hits.
    always_comb begin
        value_o = VALUE_NONE;
        match_o = 1'b0;
        for (int i = 0; i < GLYPH_COUNT; i++) begin
            if (pattern_i == GLYPH_TABLE[4'(i)]) begin
                match_o = 1'b1;
                value_o = (i == GLYPH_COUNT - 1) ? VALUE_BLANK : 4'(i);
            end
        end
    end

endmodule

// File: rtl/ssd_readback.sv
// Seven-segment glyph readback: polls the centre of each of the 36 glyph cells on the
// display matrix, captures the hit bits and decodes them back to a digit value.
// Optional macro SSD_READBACK_MAJORITY_EN: each cell is sampled three times and the
// stored bit is the 2-of-3 majority (WAIT stretched by two cycles).
module ssd_readback
    import ssd_glyph_pkg::*;
#(
    parameter int unsigned HIT_LATENCY = 1
) (
    input logic           clk,
    input logic           reset,
    ssd_readback_if.slave bus
);

`ifdef SSD_READBACK_MAJORITY_EN
    localparam int unsigned WaitCycles = HIT_LATENCY + 2;
`else
    localparam int unsigned WaitCycles = HIT_LATENCY;
`endif
    localparam logic [3:0] WaitLast = 4'(WaitCycles - 1);

    rb_state_e             state_q, state_d;
    logic [10:0]           objx_q, objx_d;
    logic [9:0]            objy_q, objy_d;
    logic [3:0]            scale_q, scale_d;
    logic [1:0]            col_q, col_d;
    logic [3:0]            row_q, row_d;
    logic [3:0]            wait_q, wait_d;
    logic [GLYPH_BITS-1:0] cap_q, cap_d;
    logic [9:0]            pollx_q, pollx_d;
    logic [8:0]            polly_q, polly_d;
    logic [3:0]            value_q, value_d;
    logic                  error_q, error_d;

    // 20 bits holds the largest row offset (8 << 15) plus origin without wrapping.
    logic [19:0] half_w, x_w, y_w;
    logic        out_of_range;
    logic        hit_bit;
    logic [3:0]  dec_value;
    logic        dec_match;

`ifdef SSD_READBACK_MAJORITY_EN
    logic [1:0] vote_q, vote_d;

    // Older two samples plus the current Hit form the vote.
    assign hit_bit = (vote_q[1] & vote_q[0]) | (vote_q[1] & bus.Hit) | (vote_q[0] & bus.Hit);
`else
    assign hit_bit = bus.Hit;
`endif

    // Cell-centre coordinates for the current (column, row) and the range check.
    always_comb begin
        half_w       = (20'd1 << scale_q) >> 1;
        x_w          = 20'(objx_q) + (20'(col_q) << scale_q) + half_w;
        y_w          = 20'(objy_q) + (20'(row_q) << scale_q) + half_w;
        out_of_range = (x_w >= 20'd1024) || (y_w >= 20'd512);
    end

    ssd_glyph_decode u_decode (
        .pattern_i (cap_q),
        .value_o   (dec_value),
        .match_o   (dec_match)
    );

    // Scan sequencer next-state and datapath updates.
    always_comb begin
        state_d = state_q;
        objx_d  = objx_q;
        objy_d  = objy_q;
        scale_d = scale_q;
        col_d   = col_q;
        row_d   = row_q;
        wait_d  = wait_q;
        cap_d   = cap_q;
        pollx_d = pollx_q;
        polly_d = polly_q;
        value_d = value_q;
        error_d = error_q;
`ifdef SSD_READBACK_MAJORITY_EN
        vote_d  = vote_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (bus.start) begin
                    state_d = StDrive;
                    objx_d  = bus.ObjectX;
                    objy_d  = bus.ObjectY;
                    scale_d = bus.ObjectScale;
                    col_d   = '0;
                    row_d   = '0;
                    cap_d   = '0;
                    value_d = VALUE_NONE;
                    error_d = 1'b0;
                end
            end
            StDrive: begin
                wait_d = '0;
                if (out_of_range) begin
                    // Poll registers keep their last value: nothing off-screen is driven.
                    state_d = StDone;
                    value_d = VALUE_NONE;
                    error_d = 1'b1;
                end else begin
                    state_d = StWait;
                    pollx_d = x_w[9:0];
                    polly_d = y_w[8:0];
                end
            end
            StWait: begin
`ifdef SSD_READBACK_MAJORITY_EN
                vote_d = {vote_q[0], bus.Hit};
`endif
                if (wait_q == WaitLast) begin
                    cap_d[glyph_bit_idx(col_q, row_q)] = hit_bit;
                    if (row_q == 4'(GLYPH_ROWS - 1)) begin
                        row_d = '0;
                        if (col_q == 2'(GLYPH_COLS - 1)) begin
                            state_d = StDecode;
                        end else begin
                            col_d   = col_q + 2'd1;
                            state_d = StDrive;
                        end
                    end else begin
                        row_d   = row_q + 4'd1;
                        state_d = StDrive;
                    end
                end else begin
                    wait_d = wait_q + 4'd1;
                end
            end
            StDecode: begin
                value_d = dec_value;
                error_d = ~dec_match;
                state_d = StDone;
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
            objx_q  <= '0;
            objy_q  <= '0;
            scale_q <= '0;
            col_q   <= '0;
            row_q   <= '0;
            wait_q  <= '0;
            cap_q   <= '0;
            pollx_q <= '0;
            polly_q <= '0;
            value_q <= VALUE_NONE;
            error_q <= 1'b0;
`ifdef SSD_READBACK_MAJORITY_EN
            vote_q  <= '0;
`endif
        end else begin
            state_q <= state_d;
            objx_q  <= objx_d;
            objy_q  <= objy_d;
            scale_q <= scale_d;
            col_q   <= col_d;
            row_q   <= row_d;
            wait_q  <= wait_d;
            cap_q   <= cap_d;
            pollx_q <= pollx_d;
            polly_q <= polly_d;
            value_q <= value_d;
            error_q <= error_d;
`ifdef SSD_READBACK_MAJORITY_EN
            vote_q  <= vote_d;
`endif
        end
    end

    // Outputs come straight from registers or the registered state.
    always_comb begin
        bus.PollX = pollx_q;
        bus.PollY = polly_q;
        bus.Value = value_q;
        bus.Error = error_q;
        bus.Busy  = (state_q != StIdle);
        bus.Done  = (state_q == StDone);
    end

endmodule

// File: tb/tb_ssd_readback.sv
// Self-checking bench for ssd_readback: a behavioural display matrix answers polls from
// its own row-major font, and a scoreboard checks Value/Error/latency on every Done.
`timescale 1ns/1ps
module tb_ssd_readback;

    localparam int HitLatency = 1;
`ifdef SSD_READBACK_MAJORITY_EN
    localparam int WaitCyc = HitLatency + 2;
`else
    localparam int WaitCyc = HitLatency;
`endif
    localparam int ScanCycles = 36 * (WaitCyc + 1) + 2;
    localparam int Budget     = ScanCycles + 20;

    typedef struct {
        logic [3:0] value;
        logic       error;
        int         latency;
        int         acc;
    } exp_t;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    int   cyc   = 0;

    ssd_readback_if bus ();

    ssd_readback #(.HIT_LATENCY(HitLatency)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Display-matrix model state.
    int          disp_x = 0, disp_y = 0, disp_s = 0;
    logic [35:0] disp_rows = '0;
    int          fault_mode = 0;  // 0 none, 1 stuck low, 2 one-cycle glitch low
    int          fault_c = 0, fault_r = 0;
    int          cell_cnt = 0;
    int          poll_changes = 0;
    logic [18:0] poll_prev = '0;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   n_done   = 0;

    // Font as 9 row nibbles, top row first, leftmost column = nibble MSB.
    function automatic logic [35:0] font_rows(input int d);
        case (d)
            0: return 36'hF9999999F;
            1: return 36'h111111111;
            2: return 36'hF111F888F;
            3: return 36'hF111F111F;
            4: return 36'h9999F1111;
            5: return 36'hF888F111F;
            6: return 36'hF888F999F;
            7: return 36'hF11111111;
            8: return 36'hF999F999F;
            9: return 36'hF999F111F;
            default: return 36'h0;
        endcase
    endfunction

    function automatic logic model_hit(input logic [9:0] px, input logic [8:0] py,
                                       input int ox, input int oy, input int s,
                                       input logic [35:0] rows, input int fmode,
                                       input int fc, input int fr, input int cnt);
        int c, r;
        if (int'(px) < ox || int'(py) < oy) return 1'b0;
        c = (int'(px) - ox) >> s;
        r = (int'(py) - oy) >> s;
        if (c > 3 || r > 8) return 1'b0;
        if (c == fc && r == fr) begin
            if (fmode == 1) return 1'b0;
            if (fmode == 2 && cnt == 1) return 1'b0;
        end
        return rows[(8 - r) * 4 + (3 - c)];
    endfunction

    always_comb bus.Hit = model_hit(bus.PollX, bus.PollY, disp_x, disp_y, disp_s, disp_rows,
                                    fault_mode, fault_c, fault_r, cell_cnt);

    // Cycles the poll has dwelt on the fault cell, and total poll coordinate changes.
    always @(posedge clk) begin
        int tx, ty;
        tx = disp_x + fault_c * (1 << disp_s) + (1 << disp_s) / 2;
        ty = disp_y + fault_r * (1 << disp_s) + (1 << disp_s) / 2;
        cell_cnt     <= (int'(bus.PollX) == tx && int'(bus.PollY) == ty) ? cell_cnt + 1 : 0;
        poll_changes <= poll_changes + (({bus.PollX, bus.PollY} != poll_prev) ? 1 : 0);
        poll_prev    <= {bus.PollX, bus.PollY};
    end

    // Scoreboard: every Done pops one expectation.
    always begin : monitor
        exp_t e;
        @(posedge clk);
        #1;
        if (bus.Done === 1'b1) begin
            n_done++;
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_done: Done=1 at cycle %0d, required no Done", cyc);
            end else begin
                e = exp_q.pop_front();
                n_checks += 4;
                if (bus.Value !== e.value) begin
                    n_fail++;
                    $display("FAIL done_value: got %h, expected %h", bus.Value, e.value);
                end
                if (bus.Error !== e.error) begin
                    n_fail++;
                    $display("FAIL done_error: got %b, expected %b", bus.Error, e.error);
                end
                if (cyc - e.acc + 1 !== e.latency) begin
                    n_fail++;
                    $display("FAIL done_latency: got %0d, expected %0d", cyc - e.acc + 1,
                             e.latency);
                end
                if (bus.Busy !== 1'b1) begin
                    n_fail++;
                    $display("FAIL busy_at_done: got %b, expected 1", bus.Busy);
                end
            end
        end
    end

    task automatic set_display(input int gx, input int gy, input int s, input int d);
        disp_x    = gx;
        disp_y    = gy;
        disp_s    = s;
        disp_rows = font_rows(d);
    endtask

    // Pulse start for one cycle (DUT must be idle) and record the expected outcome.
    task automatic issue(input int ox, input int oy, input int s, input logic [3:0] ev,
                         input logic ee, input int lat);
        exp_t e;
        @(negedge clk);
        bus.start       = 1'b1;
        bus.ObjectX     = 11'(ox);
        bus.ObjectY     = 10'(oy);
        bus.ObjectScale = 4'(s);
        e.value   = ev;
        e.error   = ee;
        e.latency = lat;
        e.acc     = cyc + 1;
        exp_q.push_back(e);
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    // Wait until all expectations are consumed, then step into the IDLE cycle after DONE.
    task automatic wait_drain(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < Budget; i++) begin
            @(posedge clk);
            #2;
            if (exp_q.size() == 0) begin
                ok = 1'b1;
                break;
            end
        end
        @(posedge clk);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        n_checks += 6;
        if (bus.Busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b, expected 0", bus.Busy); end
        if (bus.Done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b, expected 0", bus.Done); end
        if (bus.Error !== 1'b0) begin n_fail++; $display("FAIL reset_error: got %b, expected 0", bus.Error); end
        if (bus.Value !== 4'hF) begin n_fail++; $display("FAIL reset_value: got %h, expected f", bus.Value); end
        if (bus.PollX !== 10'd0) begin n_fail++; $display("FAIL reset_pollx: got %0d, expected 0", bus.PollX); end
        if (bus.PollY !== 9'd0) begin n_fail++; $display("FAIL reset_polly: got %0d, expected 0", bus.PollY); end
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_digit7();
        bit ok;
        set_display(100, 50, 2, 7);
        issue(100, 50, 2, 4'd7, 1'b0, ScanCycles);
        wait_drain(ok);
        n_checks++;
        if (!ok) begin n_fail++; $display("FAIL digit7_timeout: no Done in %0d cycles", Budget); end
    endtask

    task automatic test_all_glyphs();
        bit ok;
        for (int d = 0; d <= 10; d++) begin
            set_display(5 + d * 7, 3 + d, 0, d);
            issue(5 + d * 7, 3 + d, 0, (d < 10) ? 4'(d) : 4'hE, 1'b0, ScanCycles);
            wait_drain(ok);
            n_checks++;
            if (!ok) begin n_fail++; $display("FAIL glyph_timeout: glyph %0d no Done", d); end
        end
        // Glyph touching the last legal pixel in both axes (x=1023, y=511).
        set_display(1020, 503, 0, 1);
        issue(1020, 503, 0, 4'd1, 1'b0, ScanCycles);
        wait_drain(ok);
        n_checks++;
        if (!ok) begin n_fail++; $display("FAIL edge_timeout: no Done"); end
    endtask

    task automatic test_fault_bit();
        bit ok;
        set_display(200, 100, 1, 8);
        fault_c    = 1;
        fault_r    = 4;
        fault_mode = 1;
        issue(200, 100, 1, 4'hF, 1'b1, ScanCycles);
        wait_drain(ok);
        n_checks++;
        if (!ok) begin n_fail++; $display("FAIL stuck_timeout: no Done"); end
`ifdef SSD_READBACK_MAJORITY_EN
        fault_mode = 2;
        issue(200, 100, 1, 4'd8, 1'b0, ScanCycles);
        wait_drain(ok);
        n_checks++;
        if (!ok) begin n_fail++; $display("FAIL glitch_timeout: no Done"); end
`endif
        fault_mode = 0;
    endtask

    task automatic test_abort();
        bit ok;
        int pc;
        logic [9:0] px;
        set_display(0, 0, 0, 8);
        pc = poll_changes;
        px = bus.PollX;
        issue(1020, 10, 3, 4'hF, 1'b1, 2);
        wait_drain(ok);
        n_checks += 3;
        if (!ok) begin n_fail++; $display("FAIL abortx_timeout: no Done"); end
        if (poll_changes !== pc) begin
            n_fail++;
            $display("FAIL abortx_polls: got %0d poll changes, expected 0", poll_changes - pc);
        end
        if (bus.PollX !== px) begin
            n_fail++;
            $display("FAIL abortx_pollx: got %0d, expected %0d", bus.PollX, px);
        end
        // Y overflows on the third sample of column 0.
        issue(10, 505, 2, 4'hF, 1'b1, 2 * (WaitCyc + 1) + 2);
        wait_drain(ok);
        n_checks++;
        if (!ok) begin n_fail++; $display("FAIL aborty_timeout: no Done"); end
    endtask

    task automatic test_reset_mid();
        bit ok;
        int nd;
        set_display(40, 40, 1, 3);
        issue(40, 40, 1, 4'd3, 1'b0, ScanCycles);
        // issue returns in the DRIVE cycle of sample 0; advance to sample 20's DRIVE.
        repeat (20 * (WaitCyc + 1)) @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        exp_q.delete();
        nd = n_done;
        n_checks += 3;
        if (bus.Busy !== 1'b0) begin n_fail++; $display("FAIL midreset_busy: got %b, expected 0", bus.Busy); end
        if (bus.PollX !== 10'd0) begin n_fail++; $display("FAIL midreset_pollx: got %0d, expected 0", bus.PollX); end
        if (bus.Done !== 1'b0) begin n_fail++; $display("FAIL midreset_done: got %b, expected 0", bus.Done); end
        @(negedge clk);
        reset = 1'b0;
        repeat (ScanCycles) @(posedge clk);
        #1;
        n_checks++;
        if (n_done !== nd) begin n_fail++; $display("FAIL midreset_nodone: got %0d Done pulses, expected 0", n_done - nd); end
        issue(40, 40, 1, 4'd3, 1'b0, ScanCycles);
        wait_drain(ok);
        n_checks++;
        if (!ok) begin n_fail++; $display("FAIL midreset_restart: no Done"); end
    endtask

    task automatic test_start_ignored();
        bit seen;
        int nd;
        nd = n_done;
        set_display(300, 200, 2, 5);
        issue(300, 200, 2, 4'd5, 1'b0, ScanCycles);
        repeat (10) @(negedge clk);
        // Restart attempt with different geometry; inputs stay changed for the whole scan.
        bus.start       = 1'b1;
        bus.ObjectX     = 11'd0;
        bus.ObjectY     = 10'd0;
        bus.ObjectScale = 4'd0;
        @(negedge clk);
        bus.start = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < Budget; i++) begin
            @(posedge clk);
            #1;
            if (bus.Done === 1'b1) begin
                seen = 1'b1;
                break;
            end
        end
        n_checks++;
        if (!seen) begin n_fail++; $display("FAIL busy_start_timeout: no Done"); end
        // Start presented during the DONE cycle.
        @(negedge clk);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        #1;
        n_checks++;
        if (bus.Busy !== 1'b0) begin n_fail++; $display("FAIL done_start_busy: got %b, expected 0", bus.Busy); end
        repeat (ScanCycles + 5) @(posedge clk);
        #1;
        n_checks++;
        if (n_done !== nd + 1) begin
            n_fail++;
            $display("FAIL done_count: got %0d Done pulses, expected 1", n_done - nd);
        end
    endtask

    task automatic test_back_to_back();
        bit ok;
        set_display(60, 70, 1, 2);
        issue(60, 70, 1, 4'd2, 1'b0, ScanCycles);
        wait_drain(ok);
        n_checks++;
        if (!ok) begin n_fail++; $display("FAIL b2b_first: no Done"); end
        // wait_drain leaves us in the IDLE cycle right after DONE: start here must be taken.
        set_display(60, 70, 1, 9);
        issue(60, 70, 1, 4'd9, 1'b0, ScanCycles);
        wait_drain(ok);
        n_checks++;
        if (!ok) begin n_fail++; $display("FAIL b2b_second: no Done"); end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, n_fail=%0d", n_fail);
        $fatal(1, "watchdog");
    end

    initial begin
        bus.start       = 1'b0;
        bus.ObjectX     = '0;
        bus.ObjectY     = '0;
        bus.ObjectScale = '0;
        test_reset();
        test_digit7();
        test_all_glyphs();
        test_fault_bit();
        test_abort();
        test_reset_mid();
        test_start_ignored();
        test_back_to_back();
        repeat (5) @(posedge clk);
        #1;
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL leftover_expect: got %0d pending, expected 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
